// File: rtl/median3x3_sched_if.sv
// Bundles the window input handshake, result output handshake and the
// operand/result lanes of the shared 3-input sort unit.
interface median3x3_sched_if #(
    parameter int unsigned DW = 8
) ();
    logic [9*DW-1:0] win;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   med;
    logic            out_valid;
    logic            out_ready;
    logic            busy;
    logic [DW-1:0]   sort_d1;
    logic [DW-1:0]   sort_d2;
    logic [DW-1:0]   sort_d3;
    logic [DW-1:0]   sort_max;
    logic [DW-1:0]   sort_med;
    logic [DW-1:0]   sort_min;

    // Controller side.
    modport slave (
        input  win, in_valid, out_ready, sort_max, sort_med, sort_min,
        output in_ready, med, out_valid, busy, sort_d1, sort_d2, sort_d3
    );

    // Environment side: window source, result sink and the sort unit.
    modport master (
        output win, in_valid, out_ready, sort_max, sort_med, sort_min,
        input  in_ready, med, out_valid, busy, sort_d1, sort_d2, sort_d3
    );
endinterface

// File: rtl/median3x3_sched.sv
// 3x3 median controller: schedules seven steps on one external registered
// 3-input sort unit (row sorts, column extremes/median, final sort).
module median3x3_sched #(
    parameter int unsigned DW = 8
) (
    input logic               clk,
    input logic               rst,
    median3x3_sched_if.slave  bus
);

    typedef enum logic [3:0] {
        StIdle, StR0, StR1, StR2, StW0, StC0, StC1, StC2, StW1, StF, StW2, StOut
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] pix_q [9];
    logic [DW-1:0] max_q [3];
    logic [DW-1:0] mid_q [3];
    logic [DW-1:0] min_q [3];
    logic [DW-1:0] a_q, b_q, c_q;
    logic [DW-1:0] med_q;
    logic          out_valid_q;
    logic          accept;
    logic [DW-1:0] d1, d2, d3;

    always_comb accept = bus.in_valid && (state_q == StIdle);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StR0;
            StR0:    state_d = StR1;
            StR1:    state_d = StR2;
            StR2:    state_d = StW0;
            StW0:    state_d = StC0;
            StC0:    state_d = StC1;
            StC1:    state_d = StC2;
            StC2:    state_d = StW1;
            StW1:    state_d = StF;
            StF:     state_d = StW2;
            StW2:    state_d = StOut;
            StOut:   if (bus.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Operands are issued in their own state; the sort unit answers one cycle later.
    always_comb begin
        d1 = '0;
        d2 = '0;
        d3 = '0;
        unique case (state_q)
            StR0: begin d1 = pix_q[0]; d2 = pix_q[1]; d3 = pix_q[2]; end
            StR1: begin d1 = pix_q[3]; d2 = pix_q[4]; d3 = pix_q[5]; end
            StR2: begin d1 = pix_q[6]; d2 = pix_q[7]; d3 = pix_q[8]; end
            StC0: begin d1 = min_q[0]; d2 = min_q[1]; d3 = min_q[2]; end
            StC1: begin d1 = mid_q[0]; d2 = mid_q[1]; d3 = mid_q[2]; end
            StC2: begin d1 = max_q[0]; d2 = max_q[1]; d3 = max_q[2]; end
            StF:  begin d1 = a_q;      d2 = b_q;      d3 = c_q;      end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            med_q       <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < 9; i++) pix_q[i] <= '0;
            for (int i = 0; i < 3; i++) begin
                max_q[i] <= '0;
                mid_q[i] <= '0;
                min_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (accept) begin
                for (int i = 0; i < 9; i++) pix_q[i] <= bus.win[i*DW +: DW];
            end
            // Each capture takes the result of the step issued in the previous state.
            unique case (state_q)
                StR1: begin
                    max_q[0] <= bus.sort_max;
                    mid_q[0] <= bus.sort_med;
                    min_q[0] <= bus.sort_min;
                end
                StR2: begin
                    max_q[1] <= bus.sort_max;
                    mid_q[1] <= bus.sort_med;
                    min_q[1] <= bus.sort_min;
                end
                StW0: begin
                    max_q[2] <= bus.sort_max;
                    mid_q[2] <= bus.sort_med;
                    min_q[2] <= bus.sort_min;
                end
                StC1: a_q <= bus.sort_max;
                StC2: b_q <= bus.sort_med;
                StW1: c_q <= bus.sort_min;
                StW2: begin
                    med_q       <= bus.sort_med;
                    out_valid_q <= 1'b1;
                end
                StOut: if (bus.out_ready) out_valid_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.busy      = (state_q != StIdle);
    assign bus.med       = med_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sort_d1   = d1;
    assign bus.sort_d2   = d2;
    assign bus.sort_d3   = d3;

endmodule
